send_pulse_scheduler: RTL and testbench

//  Periodic transmit scheduler for the two TSE send_packet channels. Once the MAC is initialised and the
//  PHY RX path is ready, it issues a fixed-width cmd_send pulse to channel 1, waits for that sender to

---
 rtl/send_pulse_scheduler.sv | 123 ++++++++++++
 tb/tb_send_pulse_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/send_pulse_scheduler.sv
// Periodic two-channel transmit scheduler: WAIT_P -> pulse/drain channel 1 -> GAP -> pulse/drain channel 2.
// Each cmd_send pulse is fixed-width, and each drain is bounded by a sticky timeout flag.
module send_pulse_scheduler #(
    parameter logic [31:0]       PERIOD     = 32'h05F5E100,
    parameter logic [31:0]       CH_GAP     = 32'h01000000,
    parameter int                PULSE_LEN  = 3,
    parameter logic [31:0]       TIMEOUT    = 32'd1_000_000,
    parameter int                ADDR_W     = 25,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              busy_1,
    input  logic              busy_2,
    input  logic              clr_err,
    output logic              cmd_send_1,
    output logic              cmd_send_2,
    output logic [ADDR_W-1:0] start_ram_addr,
    output logic [15:0]       sent_cnt_1,
    output logic [15:0]       sent_cnt_2,
    output logic              err_timeout_1,
    output logic              err_timeout_2,
    output logic              active,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_P  = 3'd1,
        PULSE_1 = 3'd2,
        DRAIN_1 = 3'd3,
        GAP     = 3'd4,
        PULSE_2 = 3'd5,
        DRAIN_2 = 3'd6
    } state_t;

    localparam logic [31:0] PERIOD_LAST  = PERIOD - 32'd1;
    localparam logic [31:0] GAP_LAST     = CH_GAP - 32'd1;
    localparam logic [31:0] PULSE_LAST   = 32'(PULSE_LEN - 1);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT - 32'd1;

    state_t      state;
    state_t      next_state;
    logic [31:0] timer;
    logic        stop_req;
    logic        in_burst;
    logic        timeout_1;
    logic        timeout_2;

    assign dbg_state = state;
    assign in_burst  = (state == PULSE_1) || (state == DRAIN_1) ||
                       (state == PULSE_2) || (state == DRAIN_2);

    // A disable seen during a pulse or drain is remembered so the burst finishes before parking in IDLE.
    always_comb begin
        next_state = state;
        timeout_1  = 1'b0;
        timeout_2  = 1'b0;
        case (state)
            IDLE:    if (enable) next_state = WAIT_P;
            WAIT_P: begin
                if (!enable)                   next_state = IDLE;
                else if (timer == PERIOD_LAST) next_state = PULSE_1;
            end
            PULSE_1: if (timer == PULSE_LAST) next_state = DRAIN_1;
            DRAIN_1: begin
                if (!busy_1 || (timer == TIMEOUT_LAST)) begin
                    timeout_1  = busy_1;
                    next_state = (stop_req || !enable) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (!enable)                next_state = IDLE;
                else if (timer == GAP_LAST) next_state = PULSE_2;
            end
            PULSE_2: if (timer == PULSE_LAST) next_state = DRAIN_2;
            DRAIN_2: begin
                if (!busy_2 || (timer == TIMEOUT_LAST)) begin
                    timeout_2  = busy_2;
                    next_state = (stop_req || !enable) ? IDLE : WAIT_P;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= 32'd0;
            stop_req       <= 1'b0;
            cmd_send_1     <= 1'b0;
            cmd_send_2     <= 1'b0;
            start_ram_addr <= START_ADDR;
            sent_cnt_1     <= 16'd0;
            sent_cnt_2     <= 16'd0;
            err_timeout_1  <= 1'b0;
            err_timeout_2  <= 1'b0;
            active         <= 1'b0;
        end else begin
            state          <= next_state;
            timer          <= ((next_state != state) || (next_state == IDLE)) ? 32'd0 : timer + 32'd1;
            start_ram_addr <= START_ADDR;
            cmd_send_1     <= (next_state == PULSE_1);
            cmd_send_2     <= (next_state == PULSE_2);
            active         <= (next_state != IDLE);

            if (next_state == IDLE)        stop_req <= 1'b0;
            else if (in_burst && !enable)  stop_req <= 1'b1;

            if ((next_state == PULSE_1) && (state != PULSE_1)) sent_cnt_1 <= sent_cnt_1 + 16'd1;
            if ((next_state == PULSE_2) && (state != PULSE_2)) sent_cnt_2 <= sent_cnt_2 + 16'd1;

            // A timeout landing on the same cycle as clr_err keeps the flag set.
            if (timeout_1)    err_timeout_1 <= 1'b1;
            else if (clr_err) err_timeout_1 <= 1'b0;
            if (timeout_2)    err_timeout_2 <= 1'b1;
            else if (clr_err) err_timeout_2 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_send_pulse_scheduler.sv
// Directed bench for send_pulse_scheduler with PERIOD=16, CH_GAP=8, PULSE_LEN=3, TIMEOUT=32.
// Cycle n is the state seen after the n-th rising edge counted from the edge that first samples enable=1.
module tb_send_pulse_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        busy_1;
    logic        busy_2;
    logic        clr_err;
    logic        cmd_send_1;
    logic        cmd_send_2;
    logic [24:0] start_ram_addr;
    logic [15:0] sent_cnt_1;
    logic [15:0] sent_cnt_2;
    logic        err_timeout_1;
    logic        err_timeout_2;
    logic        active;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_1, prev_2;
    int   run_1, run_2;
    logic [31:0] exp1_q[$];
    logic [31:0] exp2_q[$];

    send_pulse_scheduler #(
        .PERIOD    (32'd16),
        .CH_GAP    (32'd8),
        .PULSE_LEN (3),
        .TIMEOUT   (32'd32),
        .ADDR_W    (25),
        .START_ADDR(25'd1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .busy_1        (busy_1),
        .busy_2        (busy_2),
        .clr_err       (clr_err),
        .cmd_send_1    (cmd_send_1),
        .cmd_send_2    (cmd_send_2),
        .start_ram_addr(start_ram_addr),
        .sent_cnt_1    (sent_cnt_1),
        .sent_cnt_2    (sent_cnt_2),
        .err_timeout_1 (err_timeout_1),
        .err_timeout_2 (err_timeout_2),
        .active        (active),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; the scoreboard watches pulse rises, widths, exclusivity and the address.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check("no_overlap", 32'(cmd_send_1 & cmd_send_2), 32'd0);
        check("start_addr", 32'(start_ram_addr), 32'd1);
        if (cmd_send_1 && !prev_1) begin
            if (exp1_q.size() == 0) check("cmd1_rise_extra", 32'(cyc), 32'hFFFF_FFFF);
            else                    check("cmd1_rise", 32'(cyc), exp1_q.pop_front());
        end
        if (cmd_send_2 && !prev_2) begin
            if (exp2_q.size() == 0) check("cmd2_rise_extra", 32'(cyc), 32'hFFFF_FFFF);
            else                    check("cmd2_rise", 32'(cyc), exp2_q.pop_front());
        end
        if (reset) begin
            run_1 = 0;
            run_2 = 0;
        end else begin
            if (cmd_send_1) run_1++;
            else if (prev_1) begin check("cmd1_width", 32'(run_1), 32'd3); run_1 = 0; end
            if (cmd_send_2) run_2++;
            else if (prev_2) begin check("cmd2_width", 32'(run_2), 32'd3); run_2 = 0; end
        end
        prev_1 = cmd_send_1;
        prev_2 = cmd_send_2;
    endtask

    task automatic reset_dut();
        reset   = 1'b1;
        enable  = 1'b0;
        busy_1  = 1'b0;
        busy_2  = 1'b0;
        clr_err = 1'b0;
        step();
        step();
        reset  = 1'b0;
        cyc    = 0;
        prev_1 = 1'b0;
        prev_2 = 1'b0;
        run_1  = 0;
        run_2  = 0;
        exp1_q.delete();
        exp2_q.delete();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_cmd1_pending"}, 32'(exp1_q.size()), 32'd0);
        check({tag, "_cmd2_pending"}, 32'(exp2_q.size()), 32'd0);
    endtask

    initial begin
        prev_1 = 1'b0;
        prev_2 = 1'b0;
        run_1  = 0;
        run_2  = 0;

        // 1: nominal sequence
        reset_dut();
        check("rst_cmd1", 32'(cmd_send_1), 32'd0);
        check("rst_cmd2", 32'(cmd_send_2), 32'd0);
        check("rst_cnt1", 32'(sent_cnt_1), 32'd0);
        check("rst_cnt2", 32'(sent_cnt_2), 32'd0);
        check("rst_err1", 32'(err_timeout_1), 32'd0);
        check("rst_err2", 32'(err_timeout_2), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        exp1_q.push_back(32'd49);
        exp2_q.push_back(32'd29);
        while (cyc < 52) begin
            step();
            check("s1_active", 32'(active), 32'd1);
            check("s1_cmd1", 32'(cmd_send_1), 32'(((cyc >= 17) && (cyc <= 19)) || ((cyc >= 49) && (cyc <= 51))));
            check("s1_cmd2", 32'(cmd_send_2), 32'((cyc >= 29) && (cyc <= 31)));
            if (cyc == 16) check("s1_cnt1_before", 32'(sent_cnt_1), 32'd0);
            if (cyc == 17) check("s1_cnt1_entry", 32'(sent_cnt_1), 32'd1);
            if (cyc == 28) check("s1_cnt2_before", 32'(sent_cnt_2), 32'd0);
            if (cyc == 32) begin
                check("s1_cnt1_after", 32'(sent_cnt_1), 32'd1);
                check("s1_cnt2_after", 32'(sent_cnt_2), 32'd1);
            end
            if (cyc == 50) check("s1_cnt1_second", 32'(sent_cnt_1), 32'd2);
        end
        check_drained("s1");

        // 2: channel-1 sender stays busy until 10 cycles after its pulse
        reset_dut();
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        exp2_q.push_back(32'd38);
        while (cyc < 45) begin
            busy_1 = (cyc >= 17) && (cyc <= 28);
            step();
        end
        busy_1 = 1'b0;
        check("s2_err1", 32'(err_timeout_1), 32'd0);
        check("s2_cnt2", 32'(sent_cnt_2), 32'd1);
        check_drained("s2");

        // 3: channel-2 sender stuck busy; sticky flag, set-wins, then clear
        reset_dut();
        enable = 1'b1;
        busy_2 = 1'b1;
        exp1_q.push_back(32'd17);
        exp1_q.push_back(32'd80);
        exp1_q.push_back(32'd143);
        exp2_q.push_back(32'd29);
        exp2_q.push_back(32'd92);
        while (cyc < 146) begin
            clr_err = (cyc == 126) || (cyc == 130);
            step();
            if (cyc == 63)  check("s3_err2_drain", 32'(err_timeout_2), 32'd0);
            if (cyc == 64)  check("s3_err2_set", 32'(err_timeout_2), 32'd1);
            if (cyc == 110) check("s3_err2_sticky", 32'(err_timeout_2), 32'd1);
            if (cyc == 127) check("s3_err2_set_wins", 32'(err_timeout_2), 32'd1);
            if (cyc == 130) check("s3_err2_hold", 32'(err_timeout_2), 32'd1);
            if (cyc == 131) check("s3_err2_cleared", 32'(err_timeout_2), 32'd0);
        end
        clr_err = 1'b0;
        busy_2  = 1'b0;
        check("s3_err1", 32'(err_timeout_1), 32'd0);
        check_drained("s3");

        // 4: enable drops mid pulse, burst completes, then re-enable at cycle 40
        reset_dut();
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        exp1_q.push_back(32'd57);
        while (cyc < 61) begin
            if (cyc == 18) enable = 1'b0;
            if (cyc == 40) enable = 1'b1;
            step();
            check("s4_cmd1", 32'(cmd_send_1), 32'(((cyc >= 17) && (cyc <= 19)) || ((cyc >= 57) && (cyc <= 59))));
            check("s4_cmd2", 32'(cmd_send_2), 32'd0);
            check("s4_active", 32'(active), 32'(((cyc >= 1) && (cyc <= 20)) || (cyc >= 41)));
        end
        check_drained("s4");

        // 5a: enable drops during GAP
        reset_dut();
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        while (cyc < 40) begin
            if (cyc == 25) enable = 1'b0;
            step();
            if (cyc == 25) check("s5a_active_gap", 32'(active), 32'd1);
            if (cyc == 26) begin
                check("s5a_active", 32'(active), 32'd0);
                check("s5a_state", 32'(dbg_state), 32'd0);
                check("s5a_cmd2", 32'(cmd_send_2), 32'd0);
            end
        end
        check_drained("s5a");

        // 5b: reset asserted during PULSE_2
        reset_dut();
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        exp2_q.push_back(32'd29);
        while (cyc < 31) begin
            if (cyc == 30) reset = 1'b1;
            step();
            if (cyc == 30) check("s5b_cnt2_pre", 32'(sent_cnt_2), 32'd1);
        end
        check("s5b_cmd1", 32'(cmd_send_1), 32'd0);
        check("s5b_cmd2", 32'(cmd_send_2), 32'd0);
        check("s5b_active", 32'(active), 32'd0);
        check("s5b_cnt1", 32'(sent_cnt_1), 32'd0);
        check("s5b_cnt2", 32'(sent_cnt_2), 32'd0);
        check_drained("s5b");

        // 6: counter wrap from 16'hFFFF
        reset_dut();
        enable = 1'b1;
        exp1_q.push_back(32'd17);
        exp2_q.push_back(32'd29);
        while (cyc < 33) begin
            if (cyc == 5) force dut.sent_cnt_1 = 16'hFFFF;
            step();
            if (cyc == 6) release dut.sent_cnt_1;
            if (cyc == 10) check("s6_cnt1_preload", 32'(sent_cnt_1), 32'h0000_FFFF);
            if (cyc == 17) check("s6_cnt1_wrap", 32'(sent_cnt_1), 32'd0);
        end
        check("s6_cnt2", 32'(sent_cnt_2), 32'd1);
        check_drained("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
